// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth signed multiplier: one Booth digit per clock, N/2 cycles per product.
// Define BOOTH_APPROX_EN to zero the K lowest columns of every partial product (approximate mode).
module booth_r4_seq_mult #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p_out
);

  localparam int unsigned W    = 2 * N;
  localparam int unsigned CntW = $clog2(N / 2);
  localparam int unsigned IdxW = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N / 2 - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if ((N % 2) != 0 || N < 4 || N > 32 || K > N) begin : g_param_check
    $error("booth_r4_seq_mult: N must be even in 4..32 and K must be in 0..N");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Booth digit select for the current iteration; b[-1] is the appended zero.
  logic [N:0]      b_ext;
  logic [IdxW-1:0] base;
  logic [2:0]      triplet;
  logic            neg, one, two;
  logic [N:0]      pp_sel, pp_bits;
  logic [W-1:0]    pp_wide, pp_sh, neg_sh, pp_add, neg_add;

  always_comb begin
    b_ext   = {b_q, 1'b0};
    base    = IdxW'({cnt_q, 1'b0});
    triplet = b_ext[base +: 3];
    neg     = triplet[2];
    one     = triplet[1] ^ triplet[0];
    two     = (triplet == 3'b011) || (triplet == 3'b100);
    pp_sel  = ({(N + 1){one}} & {a_q[N-1], a_q}) | ({(N + 1){two}} & {a_q, 1'b0});
    // Sign is taken from the inverted bits; the +1 lands in column 2i via neg_sh, so -2*(-2^(N-1))
    // does not overflow the N+1 bit field.
    pp_bits = pp_sel ^ {(N + 1){neg}};
    pp_wide = {{(N - 1){pp_bits[N]}}, pp_bits};
    pp_sh   = pp_wide << base;
    neg_sh  = {{(W - 1){1'b0}}, neg} << base;
  end

`ifdef BOOTH_APPROX_EN
  localparam logic [W-1:0] One      = W'(1);
  localparam logic [W-1:0] KeepMask = ~((One << K) - One);

  assign pp_add  = pp_sh & KeepMask;
  assign neg_add = neg_sh & KeepMask;
`else
  assign pp_add  = pp_sh;
  assign neg_add = neg_sh;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + pp_add + neg_add;
        cnt_d = cnt_q + CntOne;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign p_out     = acc_q;

endmodule

// File: doc/booth_r4_seq_mult.md
BOOTH_R4_SEQ_MULT -- requirements
Module: booth_r4_seq_mult

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 Parameter N, default 8: operand width in bits, even, legal range 4..32.
REQ-003 Parameter K, default 4: number of approximated low product columns, legal range 0..N.
REQ-004 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: operand pair offered.
REQ-007 Port in_ready, output, 1 bit: block can accept an operand pair.
REQ-008 Port a_in, input, N bits: multiplicand, signed two's complement.
REQ-009 Port b_in, input, N bits: multiplier, signed two's complement; Booth-encoded.
REQ-010 Port out_valid, output, 1 bit: product available.
REQ-011 Port out_ready, input, 1 bit: consumer takes the product.
REQ-012 Port p_out, output, 2N bits: signed product.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-014 IDLE with in_valid=1 SHALL register a_in, b_in, clear the 2N-bit accumulator and the iteration counter, and go to RUN on that edge.
REQ-015 Each RUN edge i (i=0..N/2-1) SHALL encode triplet {b[2i+1], b[2i], b[2i-1]} (b[-1]=0) into digit d in {-2,-1,0,+1,+2}.
REQ-016 On each RUN edge, d*a SHALL be sign-extended to 2N bits, shifted left by 2i, and added to the accumulator modulo 2^(2N).
REQ-017 The decoded partial-product bits SHALL be formed from the neg, one and two select signals, with two's-complement negation completed by the neg bit in column 2i.
REQ-018 After the edge with i=N/2-1, the FSM SHALL go to DONE; out_valid is therefore first high N/2 cycles after the accepting edge.
REQ-019 In DONE, p_out SHALL hold the accumulator stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-020 in_valid and a_in/b_in changes during RUN or DONE SHALL be ignored; there is no back-to-back accept from DONE.
REQ-021 When out_ready=1 arrives in the same cycle out_valid first rises, that edge SHALL complete the transfer.
REQ-022 Exact mode SHALL produce p_out = a*b for all operands, including a=b=-2^(N-1).

Reset
REQ-023 While rst_n=0, the state SHALL be IDLE, the accumulator, counter and operand registers SHALL be 0, and in_ready=1, out_valid=0, p_out=0.
REQ-024 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no output; the first accept after release starts a fresh product.

Configuration
REQ-025 With macro BOOTH_APPROX_EN defined, each shifted partial product SHALL have bit columns [K-1:0] forced to 0 before accumulation, including the neg completion bit; p_out[K-1:0] is therefore always 0.
REQ-026 Without BOOTH_APPROX_EN, K SHALL be ignored, the block is exact, and no truncation logic is present.

Verification
REQ-027 With N=8, exact build, a=7, b=-3: p_out=16'hFFEB with out_valid high exactly 4 cycles after the accept edge.
REQ-028 With N=8, exact build, a=-128, b=-128: p_out=16'h4000, and a=-128, b=127 gives p_out=16'hC080.
REQ-029 With N=8, K=4, BOOTH_APPROX_EN defined, a=7, b=3: p_out=16'h0000 (exact value 21); a=0x40, b=0x40 gives p_out=16'h1000.
REQ-030 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a_in and b_in: p_out stays stable, in_ready stays 0, and one accept occurs after out_ready=1.
REQ-031 Pulse rst_n low at RUN iteration 2: out_valid never rises for that operation, and the next pair a=5, b=6 yields p_out=16'h001E.
REQ-032 Run 10000 random signed pairs for N=8 and N=16 in the exact build: every p_out matches the a*b reference model.
